// File: rtl/program_counter_pkg.sv
// Processor-wide fetch constants shared by the program counter and the fetch stage.
// Reset address, step size and instruction alignment are defined once here.
package program_counter_pkg;

    localparam int unsigned INSTR_ALIGN_W = 2;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0004_0000;
    localparam int unsigned PC_STEP       = 4;

    typedef logic [31:0] pc_addr_t;

    // Clear the low alignment bits so an address always names a whole instruction.
    function automatic pc_addr_t align_addr(input pc_addr_t addr);
        return {addr[31:INSTR_ALIGN_W], {INSTR_ALIGN_W{1'b0}}};
    endfunction

    function automatic logic is_misaligned(input pc_addr_t addr);
        return addr[INSTR_ALIGN_W-1:0] != '0;
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Control and address bundle between a fetch/branch unit (master) and the PC (slave).
interface program_counter_if;
    import program_counter_pkg::*;

    logic     en;
    logic     ld;
    pc_addr_t ld_addr;
    pc_addr_t PC;
    pc_addr_t PC_next;
    logic     misalign;

    modport master (
        output en, ld, ld_addr,
        input  PC, PC_next, misalign
    );

    modport slave (
        input  en, ld, ld_addr,
        output PC, PC_next, misalign
    );

endinterface

// File: rtl/program_counter.sv
// Instruction program counter: redirect load beats sequential advance beats hold.
// PC_next exposes the value PC will take at the coming edge with zero latency.
module program_counter
    import program_counter_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = PC_RESET_ADDR,
    parameter int unsigned STEP       = PC_STEP
) (
    input logic              clk,
    input logic              rst,
    program_counter_if.slave bus
);

    localparam pc_addr_t RESET_ALIGNED = align_addr(RESET_ADDR);
    localparam pc_addr_t STEP_C        = align_addr(pc_addr_t'(STEP));

    pc_addr_t pc_q, pc_d;
    logic     misalign_q, misalign_d;

    // An unknown ld/en falls through to the hold branch.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (bus.ld) begin
            pc_d       = align_addr(bus.ld_addr);
            misalign_d = is_misaligned(bus.ld_addr);
        end else if (bus.en) begin
            pc_d = pc_q + STEP_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_ALIGNED;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_next  = rst ? RESET_ALIGNED : pc_d;
    assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with an arithmetic reference model checked every cycle.
module tb_program_counter;

    localparam logic [31:0] RA = 32'h0004_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    program_counter_if bus_if ();

    program_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Reference state: byte address and sticky misalignment flag.
    logic [31:0] m_pc  = RA;
    logic        m_mis = 1'b0;

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic e,
                                               input logic l, input logic [31:0] a);
        longint sum;
        if (l === 1'b1) return a - (a % 4);
        if (e === 1'b1) begin
            sum = (longint'(pc) + 4) % 64'h1_0000_0000;
            return sum[31:0];
        end
        return pc;
    endfunction

    always @(posedge rst) begin
        m_pc  = RA;
        m_mis = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pc  = RA;
            m_mis = 1'b0;
        end else begin
            if (bus_if.ld === 1'b1) m_mis = (bus_if.ld_addr % 4) != 0;
            m_pc = model_next(m_pc, bus_if.en, bus_if.ld, bus_if.ld_addr);
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk32("cyc_pc", bus_if.PC, m_pc);
        chk1("cyc_misalign", bus_if.misalign, m_mis);
        chk32("cyc_pc_next", bus_if.PC_next,
              rst ? RA : model_next(m_pc, bus_if.en, bus_if.ld, bus_if.ld_addr));
        chk1("cyc_pc_lsb", bus_if.PC[1:0] == 2'b00, 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus_if.en      = 1'b0;
        bus_if.ld      = 1'b0;
        bus_if.ld_addr = '0;

        // Reset for three edges, then free-running fetch.
        repeat (3) tick();
        chk32("rst_pc", bus_if.PC, 32'h0004_0000);
        chk1("rst_mis", bus_if.misalign, 1'b0);
        chk32("rst_pc_next", bus_if.PC_next, 32'h0004_0000);
        rst       = 1'b0;
        bus_if.en = 1'b1;
        #1 chk32("rel_pc", bus_if.PC, 32'h0004_0000);
        tick(); chk32("adv1", bus_if.PC, 32'h0004_0004);
        tick(); chk32("adv2", bus_if.PC, 32'h0004_0008);

        // Load beats advance.
        bus_if.ld      = 1'b1;
        bus_if.ld_addr = 32'h0004_0100;
        tick(); chk32("ld_pc", bus_if.PC, 32'h0004_0100);
        chk1("ld_mis", bus_if.misalign, 1'b0);
        bus_if.ld = 1'b0;
        tick(); chk32("ld_then_adv", bus_if.PC, 32'h0004_0104);

        // Misaligned load is truncated and flagged; advances keep the flag.
        bus_if.ld      = 1'b1;
        bus_if.ld_addr = 32'h0004_0203;
        tick(); chk32("mis_pc", bus_if.PC, 32'h0004_0200);
        chk1("mis_flag", bus_if.misalign, 1'b1);
        bus_if.ld = 1'b0;
        tick(); chk32("mis_adv1", bus_if.PC, 32'h0004_0204);
        chk1("mis_keep1", bus_if.misalign, 1'b1);
        tick(); chk32("mis_adv2", bus_if.PC, 32'h0004_0208);
        chk1("mis_keep2", bus_if.misalign, 1'b1);

        // Asynchronous reset between edges acts at once.
        #1 rst = 1'b1;
        #1 chk32("arst_pc", bus_if.PC, 32'h0004_0000);
        chk1("arst_mis", bus_if.misalign, 1'b0);
        chk32("arst_pc_next", bus_if.PC_next, 32'h0004_0000);
        bus_if.ld      = 1'b1;
        bus_if.ld_addr = 32'h0000_1000;
        tick(); chk32("rst_hold", bus_if.PC, 32'h0004_0000);
        bus_if.ld = 1'b0;
        rst       = 1'b0;
        tick(); chk32("rst_first_adv", bus_if.PC, 32'h0004_0004);

        // Aligned load clears a set flag.
        bus_if.ld      = 1'b1;
        bus_if.ld_addr = 32'h0004_0203;
        tick(); chk1("mis_set_again", bus_if.misalign, 1'b1);
        bus_if.ld_addr = 32'h0004_0300;
        tick(); chk32("clr_pc", bus_if.PC, 32'h0004_0300);
        chk1("clr_mis", bus_if.misalign, 1'b0);

        // Wrap at the top of the address space.
        bus_if.ld_addr = 32'hFFFF_FFFC;
        tick(); chk32("top_pc", bus_if.PC, 32'hFFFF_FFFC);
        bus_if.ld = 1'b0;
        #1 chk32("wrap_pc_next", bus_if.PC_next, 32'h0000_0000);
        tick(); chk32("wrap_pc", bus_if.PC, 32'h0000_0000);
        chk1("wrap_mis", bus_if.misalign, 1'b0);

        // Misaligned top address: flag survives the wrap.
        bus_if.ld      = 1'b1;
        bus_if.ld_addr = 32'hFFFF_FFFF;
        tick(); chk32("top_mis_pc", bus_if.PC, 32'hFFFF_FFFC);
        chk1("top_mis_flag", bus_if.misalign, 1'b1);
        bus_if.ld = 1'b0;
        tick(); chk32("top_mis_wrap", bus_if.PC, 32'h0000_0000);
        chk1("top_mis_keep", bus_if.misalign, 1'b1);

        // Hold for five edges.
        bus_if.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk32("hold_pc", bus_if.PC, 32'h0000_0000);
            chk32("hold_pc_next", bus_if.PC_next, 32'h0000_0000);
            chk1("hold_mis", bus_if.misalign, 1'b1);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
